eth_tx_frame_queue: RTL

Multi-slot transmit frame queue between the Ethernet MMIO register interface and the MAC AXI-Stream TX input, all in the BP clock domain. It generalises the single-frame TX path with these additions:
- parametrised stream width and slot count;
- byte-exact lengths via `tkeep`;
- abort;
- bad-frame marking on `tuser`;
- status counters for software polling.

Software streams payload words into a fill slot and commits the frame with a byte length. The queue then drains committed frames in order as AXIS packets.

---
 rtl/eth_pkg.sv | 24 ++
 rtl/bsg_mem_1r1w.sv | 30 +++
 rtl/eth_tx_frame_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions.
//   drain_state_e : state encoding for the TX queue drain FSM
//   keep_from_len : byte-enable mask for the final beat of a frame
//                   (len bytes, bytes per beat); returns up to 64 lanes,
//                   callers slice the low B lanes they need.
package eth_pkg;

    typedef enum logic [0:0] {
        e_idle = 1'b0,
        e_send = 1'b1
    } drain_state_e;

    function automatic logic [63:0] keep_from_len(input int len, input int bytes);
        logic [63:0] k;
        int          n;
        n = ((len - 1) % bytes) + 1;
        k = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < n) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// Simple dual-port storage: one synchronous write port, one combinational
// read port, single clock. No reset on the array contents.
//   clk_i    : clock
//   w_v_i    : write enable
//   w_addr_i : write address
//   w_data_i : write data
//   r_addr_i : read address
//   r_data_o : read data (combinational)
module bsg_mem_1r1w #(
    parameter int width_p = 64,
    parameter int els_p   = 32,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) mem_r[w_addr_i] <= w_data_i;
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/eth_tx_frame_queue.sv
// Multi-slot Ethernet transmit frame queue. Software fills a slot word by
// word and commits it with a byte length; committed frames drain in order
// as AXI-Stream packets with byte-exact tkeep and bad-frame tuser.
//   clk_i, reset_i            : clock, async active-high reset
//   wr_data_*                 : payload word input, yumi = consumed
//   commit_len_i/commit_v_i   : commit the fill slot with a byte length
//   commit_ready_o            : commit accepted when high
//   abort_v_i                 : discard the partial fill
//   tx_axis_*                 : AXIS master towards the MAC
//   frames_pending_o          : committed frames not yet fully sent
//   overflow_o/clear_overflow_i : sticky write-past-end flag and its clear
//   drop_count_o              : saturating count of rejected commits
//
// Drain FSM:
//   state  | meaning
//   e_idle | no frame on the bus; load next slot's len/bad when pending
//   e_send | presenting words of drain_slot_r until the tlast handshake
module eth_tx_frame_queue
    import eth_pkg::*;
#(
    parameter int data_width_p      = 64,
    parameter int slots_p           = 4,
    parameter int max_frame_bytes_p = 2048,
    localparam int bytes_lp         = data_width_p / 8,
    localparam int len_width_lp     = $clog2(max_frame_bytes_p + 1),
    localparam int cnt_width_lp     = $clog2(slots_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [data_width_p-1:0] wr_data_i,
    input  logic                    wr_data_v_i,
    output logic                    wr_data_yumi_o,
    input  logic [len_width_lp-1:0] commit_len_i,
    input  logic                    commit_v_i,
    output logic                    commit_ready_o,
    input  logic                    abort_v_i,
    output logic [data_width_p-1:0] tx_axis_tdata_o,
    output logic [bytes_lp-1:0]     tx_axis_tkeep_o,
    output logic                    tx_axis_tvalid_o,
    input  logic                    tx_axis_tready_i,
    output logic                    tx_axis_tlast_o,
    output logic                    tx_axis_tuser_o,
    output logic [cnt_width_lp-1:0] frames_pending_o,
    output logic                    overflow_o,
    input  logic                    clear_overflow_i,
    output logic [7:0]              drop_count_o
);

    localparam int words_lp   = max_frame_bytes_p / bytes_lp;
    localparam int slot_w_lp  = $clog2(slots_p);
    localparam int word_aw_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam int word_w_lp  = $clog2(words_lp + 1);
    localparam int byte_sh_lp = $clog2(bytes_lp);

    logic [slot_w_lp-1:0]    fill_slot_r, drain_slot_r;
    logic [word_w_lp-1:0]    fill_word_r;
    logic [word_aw_lp-1:0]   drain_word_r;
    logic [cnt_width_lp-1:0] pending_r;
    logic                    fill_bad_r, overflow_r;
    logic [7:0]              drop_r;
    logic [len_width_lp-1:0] len_r [slots_p];
    logic                    bad_r [slots_p];
    logic [len_width_lp-1:0] cur_len_r;
    logic                    cur_bad_r;
    drain_state_e            state_r;

    logic [data_width_p-1:0] rd_data;
    logic [len_width_lp-1:0] fill_bytes, last_idx;
    logic [63:0]             keep_last;
    logic not_full, wr_store, wr_over, commit_fire, len_ok, commit_good, commit_bad;
    logic sending, last_beat, handshake, frame_done;

    assign not_full       = pending_r < cnt_width_lp'(slots_p);
    assign wr_data_yumi_o = wr_data_v_i & not_full & ~commit_v_i & ~abort_v_i;
    assign commit_ready_o = not_full & ~abort_v_i;

    assign wr_store = wr_data_yumi_o & (fill_word_r <  word_w_lp'(words_lp));
    assign wr_over  = wr_data_yumi_o & (fill_word_r == word_w_lp'(words_lp));

    assign fill_bytes  = len_width_lp'(fill_word_r) << byte_sh_lp;
    assign len_ok      = (commit_len_i != '0) && (commit_len_i <= fill_bytes);
    assign commit_fire = commit_v_i & commit_ready_o;
    assign commit_good = commit_fire & len_ok;
    assign commit_bad  = commit_fire & ~len_ok;

    // The drain slot is never the fill slot, so read and write never collide.
    bsg_mem_1r1w #(
        .width_p (data_width_p),
        .els_p   (slots_p << word_aw_lp)
    ) mem (
        .clk_i    (clk_i),
        .w_v_i    (wr_store),
        .w_addr_i ({fill_slot_r, fill_word_r[word_aw_lp-1:0]}),
        .w_data_i (wr_data_i),
        .r_addr_i ({drain_slot_r, drain_word_r}),
        .r_data_o (rd_data)
    );

    assign sending    = (state_r == e_send);
    assign last_idx   = (cur_len_r - len_width_lp'(1)) >> byte_sh_lp;
    assign last_beat  = sending & (len_width_lp'(drain_word_r) == last_idx);
    assign handshake  = sending & tx_axis_tready_i;
    assign frame_done = handshake & last_beat;
    assign keep_last  = keep_from_len(int'(cur_len_r), bytes_lp);

    assign tx_axis_tvalid_o = sending;
    assign tx_axis_tdata_o  = sending ? rd_data : '0;
    assign tx_axis_tlast_o  = last_beat;
    assign tx_axis_tuser_o  = last_beat & cur_bad_r;
    assign tx_axis_tkeep_o  = !sending  ? '0 :
                              last_beat ? keep_last[bytes_lp-1:0] : '1;

    assign frames_pending_o = pending_r;
    assign overflow_o       = overflow_r;
    assign drop_count_o     = drop_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fill_slot_r <= '0;
            fill_word_r <= '0;
            fill_bad_r  <= 1'b0;
            overflow_r  <= 1'b0;
            drop_r      <= '0;
            pending_r   <= '0;
            for (int i = 0; i < slots_p; i++) begin
                len_r[i] <= '0;
                bad_r[i] <= 1'b0;
            end
        end else begin
            // commit_fire already excludes abort, so abort wins here.
            if (abort_v_i) begin
                fill_word_r <= '0;
                fill_bad_r  <= 1'b0;
            end else if (commit_good) begin
                len_r[fill_slot_r] <= commit_len_i;
                bad_r[fill_slot_r] <= fill_bad_r;
                fill_slot_r        <= fill_slot_r + slot_w_lp'(1);
                fill_word_r        <= '0;
                fill_bad_r         <= 1'b0;
            end else if (commit_bad) begin
                fill_word_r <= '0;
                fill_bad_r  <= 1'b0;
                if (drop_r != 8'hFF) drop_r <= drop_r + 8'd1;
            end else if (wr_store) begin
                fill_word_r <= fill_word_r + word_w_lp'(1);
            end else if (wr_over) begin
                fill_bad_r <= 1'b1;
            end

            if (wr_over)               overflow_r <= 1'b1;
            else if (clear_overflow_i) overflow_r <= 1'b0;

            case ({commit_good, frame_done})
                2'b10:   pending_r <= pending_r + cnt_width_lp'(1);
                2'b01:   pending_r <= pending_r - cnt_width_lp'(1);
                default: pending_r <= pending_r;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= e_idle;
            drain_slot_r <= '0;
            drain_word_r <= '0;
            cur_len_r    <= '0;
            cur_bad_r    <= 1'b0;
        end else begin
            case (state_r)
                e_idle: begin
                    if (pending_r != '0) begin
                        cur_len_r    <= len_r[drain_slot_r];
                        cur_bad_r    <= bad_r[drain_slot_r];
                        drain_word_r <= '0;
                        state_r      <= e_send;
                    end
                end
                e_send: begin
                    if (handshake) begin
                        if (last_beat) begin
                            drain_slot_r <= drain_slot_r + slot_w_lp'(1);
                            state_r      <= e_idle;
                        end else begin
                            drain_word_r <= drain_word_r + word_aw_lp'(1);
                        end
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

endmodule
